// File: rtl/dp_share_sched.sv
// Round-robin scheduler that time-shares one multicycle combinational datapath
// among NUM_REQ requesters and returns each result with its requester ID.
module dp_share_sched #(
    parameter int NUM_REQ = 4,
    parameter int DIN_W   = 10,
    parameter int DOUT_W  = 40,
    parameter int DP_LAT  = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*DIN_W-1:0] req_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DOUT_W-1:0]        rsp_data,
    output logic [DIN_W-1:0]         input_data,
    input  logic [DOUT_W-1:0]        output_data,
    output logic                     dp_start,
    output logic                     busy
);

    localparam int CNT_W = $clog2(DP_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             found;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  win_next;

    // Scanned from the far end so the requester closest to ptr is written last.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (valid[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        {found, win} = rr_pick(req_valid, rr_ptr);
        win_next     = ID_W'((int'(win) + 1) % NUM_REQ);
    end

    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && found) req_ready[win] = 1'b1;
    end

    assign busy = (state != S_IDLE);

    // input_data is held for the whole WAIT phase; output_data is sampled
    // only at the end of the last WAIT cycle (multicycle path).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            input_data <= '0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            rsp_valid  <= 1'b0;
            dp_start   <= 1'b0;
        end else begin
            dp_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        input_data <= req_data[int'(win)*DIN_W +: DIN_W];
                        rsp_id     <= win;
                        rr_ptr     <= win_next;
                        cnt        <= CNT_W'(DP_LAT);
                        dp_start   <= 1'b1;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        rsp_data  <= output_data;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_share_sched.sv
// Bench for dp_share_sched: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a timestamp-based model.
module tb_dp_share_sched;

    localparam int N   = 4;
    localparam int DW  = 10;
    localparam int OW  = 40;
    localparam int LAT = 2;
    localparam int IW  = 2;
    localparam logic [OW-1:0] XMASK = 40'hAA_0000_0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [IW-1:0]   rsp_id;
    logic [OW-1:0]   rsp_data;
    logic [DW-1:0]   input_data;
    logic [OW-1:0]   output_data;
    logic            dp_start;
    logic            busy;
    logic            glitch_en = 1'b0;

    int errors = 0;
    int checks = 0;

    // Model state: accept timestamp, pointer, last operand, expected responses.
    int                 m_cyc  = 0;
    int                 m_acc  = 0;
    logic               m_busy = 1'b0;
    int                 m_ptr  = 0;
    logic [DW-1:0]      m_op   = '0;
    logic [IW+OW-1:0]   exp_q[$];

    dp_share_sched #(.NUM_REQ(N), .DIN_W(DW), .DOUT_W(OW), .DP_LAT(LAT), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .input_data(input_data), .output_data(output_data),
        .dp_start(dp_start), .busy(busy)
    );

    always #5 clk = ~clk;

    // Datapath stub; glitches while a fresh operand is only one cycle old.
    assign output_data = (glitch_en && dp_start) ? {OW{1'b1}}
                                                 : ({{(OW-DW){1'b0}}, input_data} ^ XMASK);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_step();
        int            w;
        logic [N-1:0]  e_ready;
        logic          e_rv;
        logic [DW-1:0] op;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_op   = '0;
            exp_q.delete();
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_dp_start", dp_start, 0);
            chk("rst_input_data", input_data, 0);
        end else begin
            w       = m_busy ? -1 : pick(req_valid, m_ptr);
            e_ready = (w >= 0) ? (N'(1) << w) : '0;
            e_rv    = m_busy && (m_cyc >= m_acc + 1 + LAT);
            chk("m_req_ready", req_ready, e_ready);
            chk("m_busy", busy, m_busy);
            chk("m_rsp_valid", rsp_valid, e_rv);
            chk("m_dp_start", dp_start, m_busy && (m_cyc == m_acc + 1));
            chk("m_input_data", input_data, m_op);
            if (e_rv) begin
                if (exp_q.size() == 0) chk("m_exp_q_empty", 1, 0);
                else begin
                    chk("m_rsp_id", rsp_id, exp_q[0][OW +: IW]);
                    chk("m_rsp_data", rsp_data, exp_q[0][OW-1:0]);
                end
            end
            if (!m_busy && w >= 0) begin
                op     = req_data[w*DW +: DW];
                m_busy = 1'b1;
                m_acc  = m_cyc;
                m_ptr  = (w + 1) % N;
                m_op   = op;
                exp_q.push_back({IW'(w), {{(OW-DW){1'b0}}, op} ^ XMASK});
            end else if (e_rv && rsp_ready) begin
                void'(exp_q.pop_front());
                m_busy = 1'b0;
            end
        end
        m_cyc++;
    endtask

    always @(negedge clk) model_step();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic wait_rsp(input string name);
        for (int t = 0; t < 30; t++) begin
            sample();
            if (rsp_valid) return;
            step();
        end
        chk(name, 0, 1);
    endtask

    task automatic wait_idle(input string name);
        for (int t = 0; t < 30; t++) begin
            sample();
            if (!busy) return;
            step();
        end
        chk(name, 1, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int            got[$];
        int            gcyc[$];
        logic [N-1:0]  acc;

        // Reset values
        rst_n = 1'b0;
        sample();
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_input_data", input_data, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_dp_start", dp_start, 0);
        step();
        rst_n = 1'b1;

        // Single request from requester 2
        set_data(2, 10'h155);
        req_valid = 4'b0100;
        sample();
        chk("single_ready_c0", req_ready, 4'b0100);
        step();
        req_valid = '0;
        sample();
        chk("single_dp_start_c1", dp_start, 1);
        chk("single_input_c1", input_data, 10'h155);
        step(); sample();
        chk("single_rsp_valid_c2", rsp_valid, 0);
        step(); sample();
        chk("single_rsp_valid_c3", rsp_valid, 1);
        chk("single_rsp_data_c3", rsp_data, 40'hAA_0000_0155);
        chk("single_rsp_id_c3", rsp_id, 2);
        step(); sample();
        chk("single_done_c4", rsp_valid, 0);

        // Round robin with all four requesting
        step();
        rst_n = 1'b0;
        sample();
        step();
        rst_n = 1'b1;
        set_data(0, 10'h011); set_data(1, 10'h2C3); set_data(2, 10'h155); set_data(3, 10'h0F0);
        req_valid = 4'b1111;
        for (int t = 0; t < 40 && got.size() < 5; t++) begin
            sample();
            if (req_ready != '0) begin
                chk("rr_onehot", $countones(req_ready), 1);
                for (int i = 0; i < N; i++) if (req_ready[i]) got.push_back(i);
                gcyc.push_back(t);
            end
            step();
        end
        req_valid = '0;
        if (got.size() != 5) chk("rr_grant_count", got.size(), 5);
        else begin
            chk("rr_grant0", got[0], 0);
            chk("rr_grant1", got[1], 1);
            chk("rr_grant2", got[2], 2);
            chk("rr_grant3", got[3], 3);
            chk("rr_grant4", got[4], 0);
            for (int k = 1; k < 5; k++) chk("rr_spacing", gcyc[k] - gcyc[k-1], LAT + 2);
        end
        wait_idle("rr_idle_timeout");

        // Backpressure: 10 stalled RESP cycles, then completion
        step();
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        sample();
        chk("bp_ready", req_ready, 4'b0010);
        step();
        req_valid = 4'b1111;
        wait_rsp("bp_rsp_timeout");
        for (int k = 0; k < 10; k++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 40'hAA_0000_02C3);
            chk("bp_rsp_id", rsp_id, 1);
            chk("bp_no_ready", req_ready, 0);
            chk("bp_busy", busy, 1);
            if (k < 9) begin step(); sample(); end
        end
        step();
        rsp_ready = 1'b1;
        sample();
        chk("bp_last_valid", rsp_valid, 1);
        chk("bp_simul_no_ready", req_ready, 0);
        step(); sample();
        chk("bp_done_valid", rsp_valid, 0);
        chk("bp_done_busy", busy, 0);
        chk("bp_next_grant", req_ready, 4'b0100);
        step();
        req_valid = '0;
        wait_idle("bp_idle_timeout");

        // Sampling window: glitch in the first WAIT cycle must not be captured
        step();
        glitch_en = 1'b1;
        req_valid = 4'b1000;
        sample();
        chk("glitch_ready", req_ready, 4'b1000);
        step();
        req_valid = '0;
        wait_rsp("glitch_rsp_timeout");
        chk("glitch_rsp_data", rsp_data, 40'hAA_0000_00F0);
        chk("glitch_rsp_id", rsp_id, 3);
        wait_idle("glitch_idle_timeout");

        // Reset in the middle of WAIT
        step();
        req_valid = 4'b1111;
        sample();
        chk("rstw_pre_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("rstw_now_rsp_valid", rsp_valid, 0);
        chk("rstw_now_busy", busy, 0);
        chk("rstw_now_dp_start", dp_start, 0);
        chk("rstw_now_input", input_data, 0);
        sample();
        step();
        rst_n = 1'b1;
        req_valid = 4'b1111;
        sample();
        chk("rstw_next_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        wait_idle("rstw_idle_timeout");

        // Randomized traffic
        step();
        acc = '0;
        for (int it = 0; it < 800; it++) begin
            if (it == 400) begin
                req_valid = '0;
                rst_n = 1'b0;
            end else begin
                if (it == 401) rst_n = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i]) begin
                        if (acc[i]) begin
                            req_valid[i] = 1'($urandom_range(0, 1));
                            if (req_valid[i]) set_data(i, DW'($urandom_range(0, 1023)));
                        end else if ($urandom_range(0, 19) == 0) begin
                            req_valid[i] = 1'b0;
                        end
                    end else if ($urandom_range(0, 3) == 0) begin
                        set_data(i, DW'($urandom_range(0, 1023)));
                        req_valid[i] = 1'b1;
                    end
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            glitch_en = 1'($urandom_range(0, 1));
            sample();
            acc = req_ready;
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle("final_idle_timeout");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dp_share_sched.md
Name: dp_share_sched

Overview:
- Time-shares one instance of the 10-bit-in / 40-bit-out combinational transform datapath among NUM_REQ requesters.
- Round-robin arbitrates valid requests and registers the winner's operand onto the datapath input.
- Holds that input stable for DP_LAT cycles (multicycle path), then captures the 40-bit result into a response register.
- Returns the result with the requester ID over a valid/ready response port.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DIN_W, 10, datapath operand width
- DOUT_W, 40, datapath result width
- DP_LAT, 2, cycles the operand is held before the result is sampled (>=1; multicycle constraint on datapath)
- ID_W, $clog2(NUM_REQ), requester ID width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_data  in  NUM_REQ*DIN_W  operands, requester i at [i*DIN_W +: DIN_W]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  requester index of the response
- rsp_data  out  DOUT_W  captured datapath result
- input_data  out  DIN_W  registered operand driven to the datapath
- output_data  in  DOUT_W  datapath result
- dp_start  out  1  one-cycle pulse, first cycle a new operand is on input_data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync deassert by integration): state=IDLE, rr_ptr=0, input_data=0, rsp_data=0, rsp_id=0, rsp_valid=0, dp_start=0, wait counter=0. req_ready=0 and busy=0 follow from IDLE with no valid.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Winner w = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[w]=1, combinational from req_valid; all other ready bits 0.
  - On the accept edge: input_data <= req_data[w], rsp_id <= w, rr_ptr <= (w+1) mod NUM_REQ, cnt <= DP_LAT, dp_start <= 1, go to WAIT.
  - With no request: stay in IDLE, rr_ptr unchanged.
- WAIT:
  - req_ready=0. dp_start is high only in the first WAIT cycle. cnt decrements each cycle.
  - On the edge ending the cycle where cnt==1: rsp_data <= output_data, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id held stable.
  - When rsp_ready=1: rsp_valid <= 0, go to IDLE.
  - When rsp_ready=0: stall indefinitely.
  - No new request is accepted in RESP.
- input_data holds its last operand in all states; it changes only on an accept.
- Latency: accept at the end of cycle T puts the operand on input_data in cycle T+1. rsp_valid is first high in cycle T+1+DP_LAT. Back-to-back throughput is one transaction per DP_LAT+2 cycles.
- output_data is sampled exactly once, at the end of the last WAIT cycle. Changes to output_data at any other time have no effect.
- Fairness: a continuously requesting requester is served within NUM_REQ transactions.
- Requests are level-sensitive. A requester may drop req_valid before acceptance with no side effects. The bench must hold req_data stable while req_valid is high.
- Simultaneous events: rsp_ready in RESP and new req_valid in the same cycle → completion only; the new request is accepted in the following IDLE cycle.
- Reset mid-operation: the in-flight transaction is dropped, no response is issued, and rr_ptr returns to 0.
- Widths: no arithmetic on data; cnt width is $clog2(DP_LAT+1). When NUM_REQ is not a power of 2, rr_ptr wraps at NUM_REQ−1→0.

Test Plan:
- Bench datapath stub: output_data = {30'h0, input_data} ^ 40'hAA_0000_0000, with DP_LAT=2.
- Single request: req_valid=4'b0100 with req_data[2]=10'h155 at cycle 0. Required: req_ready=4'b0100 in cycle 0, dp_start and input_data=10'h155 in cycle 1, rsp_valid in cycle 3 with rsp_data=40'hAA_0000_0155 and rsp_id=2.
- All four request continuously, rsp_ready=1: grant order 0,1,2,3,0. Successive accepts are 4 cycles apart; exactly one req_ready bit is high per grant.
- Backpressure: rsp_ready=0 for 10 cycles in RESP. Required: rsp_valid, rsp_data and rsp_id stay stable, no req_ready is asserted, busy=1. Completion occurs on the first rsp_ready=1.
- Sampling window: the stub glitches output_data to 40'hFF..F during the first WAIT cycle. Required: the captured rsp_data still equals the correct value from the last WAIT cycle.
- Reset mid-WAIT: assert rst_n=0 for 1 cycle in WAIT. Required: outputs immediately at reset values, rsp_valid never asserted for the dropped request, and the next grant with req_valid=4'b1111 goes to requester 0.
